alu_seq: RTL and testbench

Multi-byte operation sequencer for the 8-bit combinational ALU. It accepts one NBYTES-wide operation from the control path and drives the ALU one byte per clock, chaining `shiftcarry` between bytes. It collects the byte results and returns a wide result, carry and flag with a one-cycle `done` pulse. It sits between the decode/control unit and the shared ALU; the ALU itself is unchanged.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-byte operation sequencer for the shared 8-bit ALU: walks an NBYTES-wide
// operation through the ALU one byte per clock, chaining the carry between bytes.
module alu_seq #(
   parameter int NBYTES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [8*NBYTES-1:0]   opa,
   input  logic [8*NBYTES-1:0]   opb,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  carry_out,
   output logic                  flag,
   output logic [3:0]            alu_cmd,
   output logic [7:0]            alu_inA,
   output logic [7:0]            alu_inB,
   output logic                  alu_cin,
   input  logic [7:0]            alu_rslt,
   input  logic                  alu_cout,
   input  logic                  alu_flag
);

   localparam int W = 8 * NBYTES;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_SHL = 3'b010, OP_SHR = 3'b011,
      OP_AND = 3'b100, OP_XOR = 3'b101, OP_LTU = 3'b110, OP_EQ  = 3'b111
   } op_t;

   localparam logic [3:0] CMD_AND  = 4'b0000;
   localparam logic [3:0] CMD_XOR  = 4'b0001;
   localparam logic [3:0] CMD_SHL  = 4'b0011;
   localparam logic [3:0] CMD_SHR  = 4'b0100;
   localparam logic [3:0] CMD_ADD  = 4'b0101;
   localparam logic [3:0] CMD_IDLE = 4'b0111;
   localparam logic [3:0] CMD_EQ   = 4'b1010;

   state_t         state_q, state_d;
   op_t            op_q, op_d;
   logic [W-1:0]   opa_q, opa_d;
   logic [W-1:0]   opb_q, opb_d;
   logic [1:0]     idx_q, idx_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   work_q, work_d;
   logic [W-1:0]   result_q, result_d;
   logic           cout_q, cout_d;
   logic           flag_q, flag_d;

   logic           accept;
   logic           msb_first;
   logic           last_byte;
   logic           op_msb_first;
   logic [7:0]     a_byte;
   logic [7:0]     b_byte;

   assign accept       = start && (state_q != S_RUN);
   assign msb_first    = (op_q == OP_SHR) || (op_q == OP_EQ);
   assign op_msb_first = (op_t'(op) == OP_SHR) || (op_t'(op) == OP_EQ);
   assign last_byte    = msb_first ? (idx_q == 2'd0) : (idx_q == 2'(NBYTES - 1));

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int b = 0; b < NBYTES; b++) begin
         if (idx_q == 2'(b)) begin
            a_byte = opa_q[8*b +: 8];
            b_byte = opb_q[8*b +: 8];
         end
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      work_d   = work_q;
      result_d = result_q;
      cout_d   = cout_q;
      flag_d   = flag_q;
      alu_cmd  = CMD_IDLE;
      alu_inA  = '0;
      alu_inB  = '0;
      alu_cin  = 1'b0;

      case (state_q)
         S_RUN: begin
            alu_inA = a_byte;
            alu_inB = b_byte;
            alu_cin = carry_q;
            case (op_q)
               OP_ADD:         alu_cmd = CMD_ADD;
               OP_SUB, OP_LTU: begin
                  alu_cmd = CMD_ADD;
                  alu_inB = ~b_byte;
               end
               OP_SHL:         alu_cmd = CMD_SHL;
               OP_SHR:         alu_cmd = CMD_SHR;
               OP_AND:         alu_cmd = CMD_AND;
               OP_XOR:         alu_cmd = CMD_XOR;
               default:        alu_cmd = CMD_EQ;
            endcase

            for (int b = 0; b < NBYTES; b++) begin
               if (idx_q == 2'(b)) work_d[8*b +: 8] = alu_rslt;
            end
            carry_d = alu_cout;
            idx_d   = msb_first ? idx_q - 2'd1 : idx_q + 2'd1;

            // EQ may finish early on the first mismatching byte (MSB first).
            if (last_byte || (op_q == OP_EQ && !alu_flag)) begin
               state_d  = S_DONE;
               result_d = (op_q == OP_EQ) ? '0 : work_d;
               cout_d   = (op_q == OP_ADD || op_q == OP_SUB ||
                           op_q == OP_SHL || op_q == OP_SHR) ? alu_cout : 1'b0;
               flag_d   = (op_q == OP_LTU) ? ~alu_cout :
                          (op_q == OP_EQ)  ? alu_flag  : 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         state_d = S_RUN;
         op_d    = op_t'(op);
         opa_d   = opa;
         opb_d   = opb;
         idx_d   = op_msb_first ? 2'(NBYTES - 1) : 2'd0;
         case (op_t'(op))
            OP_ADD, OP_SHL, OP_SHR: carry_d = cin;
            OP_SUB, OP_LTU:         carry_d = 1'b1;
            default:                carry_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         opa_q    <= '0;
         opb_q    <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         work_q   <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         work_q   <= work_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         flag_q   <= flag_d;
      end
   end

   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign carry_out = cout_q;
   assign flag      = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (NBYTES=2) with a behavioural model of the 8-bit ALU
// attached to the alu_* bus.
module tb_alu_seq;

   localparam int NB = 2;
   localparam int W  = 8 * NB;

   logic          clk = 1'b0;
   logic          reset, start, cin;
   logic [2:0]    op;
   logic [W-1:0]  opa, opb;
   logic          busy, done, carry_out, flag;
   logic [W-1:0]  result;
   logic [3:0]    alu_cmd;
   logic [7:0]    alu_inA, alu_inB;
   logic          alu_cin;
   logic [7:0]    m_rslt;
   logic          m_cout, m_flag;
   logic [8:0]    m_sum;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a, b;
      logic         c;
      logic [W-1:0] res;
      logic         co, fl;
      int           lat;
   } vec_t;

   always #5 clk = ~clk;

   alu_seq #(.NBYTES(NB)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out), .flag(flag),
      .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_cin(alu_cin),
      .alu_rslt(m_rslt), .alu_cout(m_cout), .alu_flag(m_flag)
   );

   // Shared 8-bit ALU behaviour for the commands the sequencer issues.
   always_comb begin
      m_sum  = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'd0, alu_cin};
      m_rslt = '0;
      m_cout = 1'b0;
      m_flag = 1'b0;
      case (alu_cmd)
         4'b0101: {m_cout, m_rslt} = m_sum;
         4'b0011: begin m_rslt = {alu_inA[6:0], alu_cin}; m_cout = alu_inA[7]; end
         4'b0100: begin m_rslt = {alu_cin, alu_inA[7:1]}; m_cout = alu_inA[0]; end
         4'b0000: m_rslt = alu_inA & alu_inB;
         4'b0001: m_rslt = alu_inA ^ alu_inB;
         4'b1010: m_flag = (alu_inA == alu_inB);
         default: ;
      endcase
   end

   function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic [W-1:0] res, input logic co,
                               input logic fl, input int lat);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.c = c; v.res = res; v.co = co; v.fl = fl; v.lat = lat;
      return v;
   endfunction

   // Drives a one-cycle start (cycle 0); returns positioned in cycle 1.
   task automatic drive_start(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c);
      op = o; opa = a; opb = b; cin = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Advances until done is seen, bounded; lat is the cycle index where it appeared.
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (done !== 1'b1 && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, carry_out, flag} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctl: busy/done/cout/flag=%b required 0000", {busy, done, carry_out, flag});
      end
      n_tests++;
      if (result !== '0) begin
         n_fail++; $display("FAIL reset_result: got %h required 0000", result);
      end
      n_tests++;
      if ({alu_cmd, alu_inA, alu_inB, alu_cin} !== {4'b0111, 8'h00, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL reset_alu_bus: cmd=%b inA=%h inB=%h cin=%b", alu_cmd, alu_inA, alu_inB, alu_cin);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_table(input string tag, input vec_t v[$]);
      int lat;
      foreach (v[i]) begin
         drive_start(v[i].op, v[i].a, v[i].b, v[i].c);
         wait_done(1, lat);
         n_tests++;
         if (lat !== v[i].lat) begin
            n_fail++; $display("FAIL %s[%0d]_latency: done in cycle %0d required %0d", tag, i, lat, v[i].lat);
         end
         n_tests++;
         if ({result, carry_out, flag} !== {v[i].res, v[i].co, v[i].fl}) begin
            n_fail++;
            $display("FAIL %s[%0d]_outputs: result=%h cout=%b flag=%b required result=%h cout=%b flag=%b",
                     tag, i, result, carry_out, flag, v[i].res, v[i].co, v[i].fl);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_arith;
      vec_t v[$];
      v.push_back(mk(3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 3));
      v.push_back(mk(3'b000, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 3));
      v.push_back(mk(3'b001, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b0, 1'b0, 3));
      v.push_back(mk(3'b110, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b0, 1'b1, 3));
      v.push_back(mk(3'b110, 16'h1235, 16'h1234, 1'b0, 16'h0001, 1'b0, 1'b0, 3));
      run_table("arith", v);
   endtask

   task automatic test_shift;
      vec_t v[$];
      v.push_back(mk(3'b010, 16'h8001, 16'h0000, 1'b1, 16'h0003, 1'b1, 1'b0, 3));
      v.push_back(mk(3'b011, 16'h8001, 16'h0000, 1'b0, 16'h4000, 1'b1, 1'b0, 3));
      v.push_back(mk(3'b011, 16'h0002, 16'h0000, 1'b1, 16'h8001, 1'b0, 1'b0, 3));
      run_table("shift", v);
   endtask

   task automatic test_logic_eq;
      vec_t v[$];
      v.push_back(mk(3'b111, 16'h12AB, 16'h34AB, 1'b0, 16'h0000, 1'b0, 1'b0, 2));
      v.push_back(mk(3'b111, 16'h12AB, 16'h12AB, 1'b0, 16'h0000, 1'b0, 1'b1, 3));
      v.push_back(mk(3'b111, 16'h12AB, 16'h12AC, 1'b1, 16'h0000, 1'b0, 1'b0, 3));
      v.push_back(mk(3'b101, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b0, 1'b0, 3));
      v.push_back(mk(3'b100, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 3));
      run_table("logic_eq", v);
   endtask

   task automatic test_ignore_start;
      int lat;
      drive_start(3'b000, 16'h00FF, 16'h0001, 1'b0);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL ignore_busy: busy=%b required 1", busy);
      end
      op = 3'b001; opa = 16'hFFFF; opb = 16'h1234; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2, lat);
      n_tests++;
      if (lat !== 3 || result !== 16'h0100 || carry_out !== 1'b0) begin
         n_fail++; $display("FAIL ignore_result: cycle %0d result=%h cout=%b required cycle 3 result=0100 cout=0",
                            lat, result, carry_out);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({busy, done} !== 2'b00) begin
         n_fail++; $display("FAIL ignore_no_queue: busy/done=%b required 00", {busy, done});
      end
   endtask

   task automatic test_reset_mid_run;
      int seen = 0;
      drive_start(3'b000, 16'h1111, 16'h2222, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_tests++;
      if ({busy, done} !== 2'b00 || result !== '0 || alu_cmd !== 4'b0111) begin
         n_fail++; $display("FAIL midrun_reset: busy/done=%b result=%h cmd=%b required 00 0000 0111",
                            {busy, done}, result, alu_cmd);
      end
      for (int i = 0; i < 5; i++) begin
         if (done === 1'b1) seen++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL midrun_no_done: done seen %0d times required 0", seen);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      drive_start(3'b000, 16'h00FF, 16'h0001, 1'b0);
      wait_done(1, lat);
      n_tests++;
      if (lat !== 3) begin
         n_fail++; $display("FAIL b2b_first: done in cycle %0d required 3", lat);
      end
      drive_start(3'b101, 16'hF0F0, 16'hFF00, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (done !== 1'b0 || busy !== 1'b1 || result !== 16'h0100) begin
            n_fail++; $display("FAIL b2b_hold%0d: done=%b busy=%b result=%h required 0 1 0100",
                               k, done, busy, result);
         end
         @(posedge clk); #1;
      end
      n_tests++;
      if (done !== 1'b1 || result !== 16'h0FF0) begin
         n_fail++; $display("FAIL b2b_second: done=%b result=%h required 1 0FF0", done, result);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_arith;
      test_shift;
      test_logic_eq;
      test_ignore_start;
      test_reset_mid_run;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
